// File: rtl/timer_8bit.sv
// 8-bit down-counting timer with start/stop, preload, one-shot or periodic reload.
// Optional macro TIMER_8BIT_TRISTATE_EN: outputs float (Z) when disabled, otherwise they read 0.
module timer_8bit (
    input  logic       Clk_In,
    input  logic       Reset_In,
    input  logic       Enable_In,
    input  logic       Start_Timer_Command_In,
    input  logic       Stop_Timer_Command_In,
    input  logic       Timer_Periodic_Oneshotb_Mode_In,
    input  logic [7:0] Preload_Timer_Value_In,
    output logic       Timer_Running_Flag_Out,
    output logic       Timer_Rollover_Flag_Out,
    output logic [7:0] Timer_Count_Out
);

    logic       running_r;
    logic       rollover_r;
    logic [7:0] value_r;

    // Timer state: first matching rule wins, so Start beats Stop only while idle.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            running_r  <= 1'b0;
            rollover_r <= 1'b0;
            value_r    <= 8'h00;
        end else if (!running_r && Start_Timer_Command_In) begin
            running_r  <= 1'b1;
            rollover_r <= 1'b0;
            value_r    <= Preload_Timer_Value_In;
        end else if (Stop_Timer_Command_In) begin
            running_r  <= 1'b0;
            rollover_r <= 1'b0;
            value_r    <= 8'h00;
        end else if (running_r) begin
            if (value_r == 8'h00) begin
                rollover_r <= 1'b1;
                if (Timer_Periodic_Oneshotb_Mode_In) begin
                    running_r <= 1'b1;
                    value_r   <= Preload_Timer_Value_In;
                end else begin
                    running_r <= 1'b0;
                    value_r   <= 8'h00;
                end
            end else begin
                running_r  <= 1'b1;
                rollover_r <= 1'b0;
                value_r    <= value_r - 8'd1;
            end
        end else begin
            running_r  <= 1'b0;
            rollover_r <= 1'b0;
            value_r    <= 8'h00;
        end
    end

    // Output enable is purely combinational; it never gates the counter itself.
`ifdef TIMER_8BIT_TRISTATE_EN
    assign Timer_Running_Flag_Out  = Enable_In ? running_r  : 1'bz;
    assign Timer_Rollover_Flag_Out = Enable_In ? rollover_r : 1'bz;
    assign Timer_Count_Out         = Enable_In ? value_r    : 8'bzzzz_zzzz;
`else
    assign Timer_Running_Flag_Out  = Enable_In ? running_r  : 1'b0;
    assign Timer_Rollover_Flag_Out = Enable_In ? rollover_r : 1'b0;
    assign Timer_Count_Out         = Enable_In ? value_r    : 8'h00;
`endif

endmodule

// File: tb/tb_timer_8bit.sv
// Scoreboard bench for timer_8bit: expected outputs queued with each stimulus step,
// popped and compared after the corresponding clock edge (or immediately for async events).
module tb_timer_8bit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [7:0] preload;
    logic       run_o;
    logic       roll_o;
    logic [7:0] cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] run;
        logic [7:0] roll;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    timer_8bit dut (
        .Clk_In                          (clk),
        .Reset_In                        (rst),
        .Enable_In                       (en),
        .Start_Timer_Command_In          (start),
        .Stop_Timer_Command_In           (stop),
        .Timer_Periodic_Oneshotb_Mode_In (periodic),
        .Preload_Timer_Value_In          (preload),
        .Timer_Running_Flag_Out          (run_o),
        .Timer_Rollover_Flag_Out         (roll_o),
        .Timer_Count_Out                 (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", tag, obs, exp);
        end
    endtask

    // What a disabled output should read in this build.
    function automatic logic [7:0] mask1(input logic b);
`ifdef TIMER_8BIT_TRISTATE_EN
        return {7'b000_0000, (en ? b : 1'bz)};
`else
        return {7'b000_0000, (en ? b : 1'b0)};
`endif
    endfunction

    function automatic logic [7:0] mask8(input logic [7:0] v);
`ifdef TIMER_8BIT_TRISTATE_EN
        return en ? v : 8'bzzzz_zzzz;
`else
        return en ? v : 8'h00;
`endif
    endfunction

    task automatic push_exp(input string tag, input logic r, input logic ro, input logic [7:0] c);
        exp_t e;
        e.tag  = tag;
        e.run  = mask1(r);
        e.roll = mask1(ro);
        e.cnt  = mask8(c);
        sb_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_value("sb_empty", 8'h01, 8'h00);
        end else begin
            e = sb_q.pop_front();
            check_value({e.tag, ".run"},  {7'b000_0000, run_o},  e.run);
            check_value({e.tag, ".roll"}, {7'b000_0000, roll_o}, e.roll);
            check_value({e.tag, ".cnt"},  cnt_o,                 e.cnt);
        end
    endtask

    // Expected state after the next rising edge, sampled 1 time unit later.
    task automatic step(input string tag, input logic r, input logic ro, input logic [7:0] c);
        push_exp(tag, r, ro, c);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // Expected state right now, with no clock edge involved.
    task automatic now(input string tag, input logic r, input logic ro, input logic [7:0] c);
        push_exp(tag, r, ro, c);
        #1;
        compare_front();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        periodic = 1'b0;
        preload  = 8'h00;
        #1;

        // Reset state and output enable behaviour while reset is held.
        now("reset", 1'b0, 1'b0, 8'h00);
        en = 1'b0;
        now("reset_dis", 1'b0, 1'b0, 8'h00);
        en = 1'b1;
        now("reset_reen", 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, 8'h00);

        // Periodic, preload 5, 15 cycles.
        periodic = 1'b1;
        preload  = 8'd5;
        start    = 1'b1;
        for (int i = 0; i < 15; i++) begin
            int ph;
            ph = i % 6;
            step("per", 1'b1, (i > 0 && ph == 0), (ph == 0) ? 8'd5 : 8'(5 - ph));
            start = 1'b0;
        end
        stop = 1'b1;
        step("per_stop", 1'b0, 1'b0, 8'h00);
        stop = 1'b0;
        step("per_idle", 1'b0, 1'b0, 8'h00);

        // One-shot, preload 5.
        periodic = 1'b0;
        start    = 1'b1;
        step("os_start", 1'b1, 1'b0, 8'd5);
        start = 1'b0;
        for (int k = 4; k >= 0; k--) step("os_cnt", 1'b1, 1'b0, 8'(k));
        step("os_expire", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step("os_idle", 1'b0, 1'b0, 8'h00);

        // One-shot, preload 15, counting continues while outputs are disabled.
        preload = 8'd15;
        start   = 1'b1;
        step("dis_start", 1'b1, 1'b0, 8'd15);
        start = 1'b0;
        for (int k = 14; k >= 12; k--) step("dis_cnt", 1'b1, 1'b0, 8'(k));
        en = 1'b0;
        now("dis_now", 1'b1, 1'b0, 8'd12);
        for (int k = 11; k >= 9; k--) step("dis_off", 1'b1, 1'b0, 8'(k));
        en = 1'b1;
        now("dis_reen", 1'b1, 1'b0, 8'd9);
        step("dis_back", 1'b1, 1'b0, 8'd8);
        stop = 1'b1;
        step("dis_stop", 1'b0, 1'b0, 8'h00);
        stop = 1'b0;

        // Start while running is ignored.
        preload = 8'd6;
        start   = 1'b1;
        step("rs_start", 1'b1, 1'b0, 8'd6);
        start = 1'b0;
        for (int k = 5; k >= 3; k--) step("rs_cnt", 1'b1, 1'b0, 8'(k));
        start   = 1'b1;
        preload = 8'd40;
        step("rs_ignored", 1'b1, 1'b0, 8'd2);
        start = 1'b0;
        step("rs_cnt1", 1'b1, 1'b0, 8'd1);
        step("rs_cnt0", 1'b1, 1'b0, 8'd0);
        step("rs_expire", 1'b0, 1'b1, 8'h00);
        step("rs_idle", 1'b0, 1'b0, 8'h00);

        // Start+Stop: Start wins when idle, Stop wins when running.
        preload = 8'd9;
        start   = 1'b1;
        stop    = 1'b1;
        step("ss_idle", 1'b1, 1'b0, 8'd9);
        step("ss_run", 1'b0, 1'b0, 8'h00);
        start = 1'b0;
        stop  = 1'b0;

        // Periodic with preload 0: rollover every cycle.
        periodic = 1'b1;
        preload  = 8'd0;
        start    = 1'b1;
        step("p0_start", 1'b1, 1'b0, 8'd0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("p0_roll", 1'b1, 1'b1, 8'd0);
        stop = 1'b1;
        step("p0_stop", 1'b0, 1'b0, 8'h00);
        stop = 1'b0;

        // Asynchronous reset mid-count.
        preload = 8'd7;
        start   = 1'b1;
        step("ar_start", 1'b1, 1'b0, 8'd7);
        start = 1'b0;
        for (int k = 6; k >= 4; k--) step("ar_cnt", 1'b1, 1'b0, 8'(k));
        #2;
        rst = 1'b1;
        now("ar_reset", 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step("ar_idle", 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
